// File: rtl/periwinkle_core_if.sv
// Instruction-fetch and external-ALU bus of periwinkle_core.
// master = core side, slave = instruction memory / ALU side.
interface periwinkle_core_if #(
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned PMEM_AW = 8
);
    logic [PMEM_AW-1:0] o_imem_addr;
    logic               o_imem_en;
    logic [DATA_W+7:0]  i_imem_data;
    logic [1:0]         o_alu_input_op;
    logic               o_alu_data_valid;
    logic [DATA_W-1:0]  o_alu_data;
    logic [1:0]         o_alu_output_op;
    logic               o_alu_result_empty;
    logic               i_alu_result_valid;
    logic [DATA_W-1:0]  i_alu_result;
    logic [4:0]         i_alu_flags;

    modport master (
        output o_imem_addr, o_imem_en,
        input  i_imem_data,
        output o_alu_input_op, o_alu_data_valid, o_alu_data,
        output o_alu_output_op, o_alu_result_empty,
        input  i_alu_result_valid, i_alu_result, i_alu_flags
    );

    modport slave (
        input  o_imem_addr, o_imem_en,
        output i_imem_data,
        input  o_alu_input_op, o_alu_data_valid, o_alu_data,
        input  o_alu_output_op, o_alu_result_empty,
        output i_alu_result_valid, i_alu_result, i_alu_flags
    );
endinterface

// File: rtl/periwinkle_core.sv
// Transport-triggered core: each instruction moves one source to one destination;
// side effects (ALU, skip, jump, RNG, data pointer, halt) are triggered by the move.
module periwinkle_core #(
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       GPR_COUNT = 32,
    parameter int unsigned       DMEM_AW   = 6,
    parameter int unsigned       PMEM_AW   = 8,
    parameter logic [DATA_W-1:0] RNG_SEED  = 32'h0000_0001,
    parameter logic [DATA_W-1:0] RNG_TAPS  = 32'h8000_07D8
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    periwinkle_core_if.master  bus,
    output logic [PMEM_AW-1:0] o_pc,
    output logic               o_halted
);

    localparam int unsigned IW  = DATA_W + 8;
    localparam int unsigned GIW = (GPR_COUNT > 1) ? $clog2(GPR_COUNT) : 1;

    typedef enum logic [1:0] {S_FETCH, S_EXEC, S_WAIT, S_HALT} state_t;

    typedef enum logic [4:0] {
        SPR_PC     = 5'd0,
        SPR_STATUS = 5'd1,
        SPR_RNG    = 5'd3,
        SPR_SIZ    = 5'd8,
        SPR_SINZ   = 5'd9,
        SPR_REF    = 5'd10,
        SPR_DEF    = 5'd11,
        SPR_HALT   = 5'd13
    } spr_t;

    function automatic logic is_spr(input logic [5:0] code, input spr_t s);
        return code == {1'b0, s};
    endfunction

    function automatic logic is_alu(input logic [5:0] code);
        return !code[5] && (code[4:2] == 3'b001);
    endfunction

    state_t              state, state_nxt;
    logic [IW-2:0]       ir;
    logic [PMEM_AW-1:0]  pc, pc_nxt;
    logic [4:0]          status;
    logic [DATA_W-1:0]   rng;
    logic [DMEM_AW-1:0]  ref_ptr;
    logic [DATA_W-1:0]   gpr  [GPR_COUNT];
    logic [DATA_W-1:0]   dmem [2**DMEM_AW];

    logic                xfer;
    logic [DATA_W-1:0]   src_field;
    logic [5:0]          src_reg;
    logic [5:0]          dst;
    logic [DATA_W-1:0]   src_val;
    logic                src_alu;
    logic                stall;
    logic                commit;
    logic                dst_alu;

    // WAIT decodes the latched IR; EXEC decodes the memory output directly.
    always_comb begin
        if (state == S_WAIT) begin
            xfer      = ir[IW-2];
            src_field = ir[IW-3:6];
            dst       = ir[5:0];
        end else begin
            xfer      = bus.i_imem_data[IW-1];
            src_field = bus.i_imem_data[IW-3:6];
            dst       = bus.i_imem_data[5:0];
        end
    end

    assign src_reg = src_field[5:0];
    assign src_alu = xfer && is_alu(src_reg);
    assign stall   = src_alu && !bus.i_alu_result_valid;
    assign commit  = ((state == S_EXEC) || (state == S_WAIT)) && !stall;
    assign dst_alu = commit && is_alu(dst);

    always_comb begin
        src_val = '0;
        if (!xfer) begin
            src_val = src_field;
        end else if (src_reg[5]) begin
            if (32'(src_reg[4:0]) < GPR_COUNT) src_val = gpr[src_reg[GIW-1:0]];
        end else begin
            case (src_reg[4:0])
                SPR_PC:                  src_val = DATA_W'(pc);
                SPR_STATUS:              src_val = DATA_W'(status);
                SPR_RNG:                 src_val = rng;
                5'd4, 5'd5, 5'd6, 5'd7:  src_val = bus.i_alu_result;
                SPR_REF:                 src_val = DATA_W'(ref_ptr);
                SPR_DEF:                 src_val = dmem[ref_ptr];
                default:                 src_val = '0;
            endcase
        end
    end

    always_comb begin
        pc_nxt = pc + PMEM_AW'(1);
        if (is_spr(dst, SPR_PC))
            pc_nxt = src_val[PMEM_AW-1:0];
        else if (is_spr(dst, SPR_SIZ) && (src_val == '0))
            pc_nxt = pc + PMEM_AW'(2);
        else if (is_spr(dst, SPR_SINZ) && (src_val != '0))
            pc_nxt = pc + PMEM_AW'(2);
    end

    // FSM: state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= S_FETCH;
        else          state <= state_nxt;
    end

    // FSM: next state
    always_comb begin
        state_nxt = state;
        case (state)
            S_FETCH: state_nxt = S_EXEC;
            S_EXEC, S_WAIT: begin
                if (stall)                      state_nxt = S_WAIT;
                else if (is_spr(dst, SPR_HALT)) state_nxt = S_HALT;
                else                            state_nxt = S_FETCH;
            end
            S_HALT:  state_nxt = S_HALT;
            default: state_nxt = S_FETCH;
        endcase
    end

    // FSM: outputs
    always_comb begin
        bus.o_imem_en          = (state == S_FETCH);
        bus.o_imem_addr        = pc;
        bus.o_alu_data_valid   = dst_alu;
        bus.o_alu_data         = dst_alu ? src_val : '0;
        bus.o_alu_input_op     = dst_alu ? dst[1:0] : '0;
        bus.o_alu_result_empty = commit && src_alu;
        bus.o_alu_output_op    = (commit && src_alu) ? src_reg[1:0] : '0;
        o_pc                   = pc;
        o_halted               = (state == S_HALT);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc      <= '0;
            status  <= '0;
            rng     <= RNG_SEED;
            ref_ptr <= '0;
            ir      <= '0;
        end else begin
            if (state == S_EXEC && stall)
                ir <= bus.i_imem_data[IW-2:0] & {1'b1, 1'b0, {(IW-3){1'b1}}} | {bus.i_imem_data[IW-1], {(IW-2){1'b0}}};
            if (commit) begin
                pc <= pc_nxt;
                if (is_spr(dst, SPR_REF)) ref_ptr <= src_val[DMEM_AW-1:0];
            end
            // An explicit STATUS move overrides the flag capture of the same cycle.
            if (commit && is_spr(dst, SPR_STATUS))
                status <= src_val[4:0];
            else if (bus.i_alu_result_valid && state != S_HALT)
                status <= bus.i_alu_flags;
            if (commit && is_spr(dst, SPR_RNG))
                rng <= src_val;
            else if (commit && xfer && is_spr(src_reg, SPR_RNG))
                rng <= {^(rng & RNG_TAPS), rng[DATA_W-1:1]};
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int unsigned i = 0; i < GPR_COUNT; i++) gpr[i] <= '0;
        end else if (commit && dst[5] && (32'(dst[4:0]) < GPR_COUNT)) begin
            gpr[dst[GIW-1:0]] <= src_val;
        end
    end

    always_ff @(posedge i_clk) begin
        if (commit && is_spr(dst, SPR_DEF)) dmem[ref_ptr] <= src_val;
    end

endmodule

// File: tb/tb_periwinkle_core.sv
// Bench for periwinkle_core: instruction-level reference model checked every cycle,
// directed programs with hand-computed results, and random programs.
module tb_periwinkle_core;
    localparam int unsigned DW   = 32;
    localparam int unsigned GPRS = 24;
    localparam int unsigned DAW  = 6;
    localparam int unsigned PAW  = 8;
    localparam logic [31:0] TAPS = 32'h8000_07D8;
    localparam logic [31:0] SEED = 32'h0000_0001;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [PAW-1:0] pc_o;
    logic halted_o;

    periwinkle_core_if #(.DATA_W(DW), .PMEM_AW(PAW)) bus ();

    periwinkle_core #(
        .DATA_W(DW), .GPR_COUNT(GPRS), .DMEM_AW(DAW), .PMEM_AW(PAW),
        .RNG_SEED(SEED), .RNG_TAPS(TAPS)
    ) dut (
        .i_clk(clk), .i_rst_n(rst_n), .bus(bus), .o_pc(pc_o), .o_halted(halted_o)
    );

    always #5 clk = ~clk;

    logic [39:0] prog [256];
    always @(posedge clk) if (bus.o_imem_en) bus.i_imem_data <= prog[bus.o_imem_addr];

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    endtask

    function automatic logic [39:0] mk(input bit xf, input logic [31:0] s, input logic [5:0] d);
        return {xf, 1'b0, s, d};
    endfunction

    function automatic logic [5:0] g(input int n);
        return 6'(32 + n);
    endfunction

    // ALU stimulus: mode 0 random, mode 1 fixed result that becomes valid from cycle valid_after
    int alu_mode = 1;
    int valid_after = 1_000_000;
    int cyc = -1;
    logic [31:0] fixed_res = '0;
    logic [4:0] fixed_flags = '0;

    always @(negedge clk) begin
        if (!rst_n) cyc = -1;
        else cyc++;
        if (alu_mode == 0) begin
            bus.i_alu_result_valid = 1'($urandom_range(0, 1));
            bus.i_alu_result = $urandom;
            bus.i_alu_flags = 5'($urandom);
        end else begin
            bus.i_alu_result_valid = (cyc >= valid_after);
            bus.i_alu_result = fixed_res;
            bus.i_alu_flags = fixed_flags;
        end
    end

    // Reference model: architectural state plus "next cycle is a fetch" / halted
    logic [7:0]  m_pc;
    logic [4:0]  m_st;
    logic [31:0] m_rng;
    logic [5:0]  m_ref;
    logic [31:0] m_g [GPRS];
    logic [31:0] m_mem [64];
    bit          m_fetch, m_halt, mem_ready = 0;
    logic [31:0] alu_log [$];
    int          n_empty = 0;

    function automatic logic [31:0] m_read(input logic [5:0] s);
        if (s[5]) return (int'(s[4:0]) < GPRS) ? m_g[s[4:0]] : 32'h0;
        case (s[4:0])
            5'd0:                   return 32'(m_pc);
            5'd1:                   return 32'(m_st);
            5'd3:                   return m_rng;
            5'd4, 5'd5, 5'd6, 5'd7: return bus.i_alu_result;
            5'd10:                  return 32'(m_ref);
            5'd11:                  return m_mem[m_ref];
            default:                return 32'h0;
        endcase
    endfunction

    logic [39:0] ins;
    logic        xf, dv, sa;
    logic [31:0] v;
    logic [5:0]  d, s;

    always @(negedge clk) begin
        #1;
        if (!mem_ready) begin
            for (int i = 0; i < 64; i++) m_mem[i] = '0;
            mem_ready = 1;
        end
        if (!rst_n) begin
            m_pc = '0; m_st = '0; m_rng = SEED; m_ref = '0;
            for (int i = 0; i < GPRS; i++) m_g[i] = '0;
            m_fetch = 1; m_halt = 0;
        end else begin
            if (bus.o_alu_data_valid === 1'b1) alu_log.push_back(bus.o_alu_data);
            if (bus.o_alu_result_empty === 1'b1) n_empty++;
            chk("halted", 32'(halted_o), 32'(m_halt));
            chk("pc", 32'(pc_o), 32'(m_pc));
            if (m_halt) begin
                chk("halt_no_fetch", 32'(bus.o_imem_en), 0);
                chk("halt_no_dv", 32'(bus.o_alu_data_valid), 0);
                chk("halt_no_empty", 32'(bus.o_alu_result_empty), 0);
            end else if (m_fetch) begin
                chk("fetch_en", 32'(bus.o_imem_en), 1);
                chk("fetch_addr", 32'(bus.o_imem_addr), 32'(m_pc));
                chk("fetch_no_dv", 32'(bus.o_alu_data_valid), 0);
                chk("fetch_no_empty", 32'(bus.o_alu_result_empty), 0);
                if (bus.i_alu_result_valid) m_st = bus.i_alu_flags;
                m_fetch = 0;
            end else begin
                ins = prog[m_pc];
                xf = ins[39];
                d = ins[5:0];
                s = ins[11:6];
                sa = xf && (s >= 6'd4) && (s <= 6'd7);
                chk("exec_no_fetch", 32'(bus.o_imem_en), 0);
                if (sa && !bus.i_alu_result_valid) begin
                    chk("stall_no_dv", 32'(bus.o_alu_data_valid), 0);
                    chk("stall_no_empty", 32'(bus.o_alu_result_empty), 0);
                end else begin
                    v = xf ? m_read(s) : ins[37:6];
                    dv = (d >= 6'd4) && (d <= 6'd7);
                    chk("alu_dv", 32'(bus.o_alu_data_valid), 32'(dv));
                    if (dv) begin
                        chk("alu_data", bus.o_alu_data, v);
                        chk("alu_in_op", 32'(bus.o_alu_input_op), 32'(d[1:0]));
                    end
                    chk("alu_empty", 32'(bus.o_alu_result_empty), 32'(sa));
                    if (sa) chk("alu_out_op", 32'(bus.o_alu_output_op), 32'(s[1:0]));
                    if (bus.i_alu_result_valid) m_st = bus.i_alu_flags;
                    if (d == 6'd1) m_st = v[4:0];
                    if (xf && s == 6'd3) m_rng = {^(m_rng & TAPS), m_rng[31:1]};
                    if (d == 6'd3) m_rng = v;
                    if (d >= 6'd32 && int'(d) - 32 < GPRS) m_g[d - 6'd32] = v;
                    if (d == 6'd11) m_mem[m_ref] = v;
                    if (d == 6'd10) m_ref = v[5:0];
                    if (d == 6'd0) m_pc = v[7:0];
                    else if (d == 6'd8 && v == 0) m_pc = m_pc + 8'd2;
                    else if (d == 6'd9 && v != 0) m_pc = m_pc + 8'd2;
                    else m_pc = m_pc + 8'd1;
                    m_halt = (d == 6'd13);
                    m_fetch = 1;
                end
            end
        end
    end

    task automatic clear_prog();
        for (int i = 0; i < 256; i++) prog[i] = mk(0, 0, 6'd13);
    endtask

    task automatic reset_dut();
        rst_n = 0;
        repeat (2) @(posedge clk);
        #2;
        alu_log.delete();
        n_empty = 0;
        rst_n = 1;
    endtask

    task automatic run_until_halt(input string nm, input int budget);
        int k = 0;
        while (!halted_o && k < budget) begin
            @(posedge clk); #1; k++;
        end
        chk(nm, 32'(halted_o), 1);
    endtask

    task automatic chk_log(input string nm, input int idx, input logic [31:0] exp);
        chk(nm, (alu_log.size() > idx) ? alu_log[idx] : 32'hxxxx_xxxx, exp);
    endtask

    initial begin
        bus.i_alu_result_valid = 0;
        bus.i_alu_result = '0;
        bus.i_alu_flags = '0;

        // 1: skip on nonzero, 2 cycles per instruction
        clear_prog();
        prog[0] = mk(0, 5, g(1));
        prog[1] = mk(1, 32'(g(1)), g(2));
        prog[2] = mk(1, 32'(g(2)), 6'd9);
        prog[3] = mk(0, 9, g(3));
        prog[4] = mk(0, 7, g(4));
        prog[5] = mk(1, 32'(g(2)), 6'd4);
        prog[6] = mk(1, 32'(g(3)), 6'd4);
        prog[7] = mk(1, 32'(g(4)), 6'd4);
        alu_mode = 1; valid_after = 1_000_000;
        reset_dut();
        chk("t1_reset_pc", 32'(pc_o), 0);
        chk("t1_reset_fetch", 32'(bus.o_imem_en), 1);
        chk("t1_reset_halted", 32'(halted_o), 0);
        repeat (8) @(posedge clk);
        #1 chk("t1_pc_after_8", 32'(pc_o), 5);
        run_until_halt("t1_halt", 100);
        chk("t1_count", alu_log.size(), 3);
        chk_log("t1_g2", 0, 5);
        chk_log("t1_g3", 1, 0);
        chk_log("t1_g4", 2, 7);

        // 2: ALU-result stall for 4 cycles
        clear_prog();
        prog[0] = mk(0, 3, 6'd4);
        prog[1] = mk(1, 5, g(0));
        prog[2] = mk(1, 32'(g(0)), 6'd4);
        prog[3] = mk(1, 1, 6'd4);
        fixed_res = 32'h2A; fixed_flags = 5'b10001; valid_after = 7;
        reset_dut();
        run_until_halt("t2_halt", 100);
        chk("t2_one_empty", n_empty, 1);
        chk_log("t2_operand", 0, 3);
        chk_log("t2_g0", 1, 32'h2A);
        chk_log("t2_status", 2, 32'h11);

        // 3: RNG sequence; feedback ^(1 & TAPS) is 0 since TAPS[0]=0
        clear_prog();
        prog[0] = mk(1, 3, g(0));
        prog[1] = mk(1, 32'(g(0)), 6'd4);
        prog[2] = mk(1, 3, g(0));
        prog[3] = mk(1, 32'(g(0)), 6'd4);
        prog[4] = mk(0, 8, 6'd3);
        prog[5] = mk(1, 3, 6'd12);
        prog[6] = mk(1, 3, 6'd4);
        prog[7] = mk(0, 32'h1234, 6'd3);
        prog[8] = mk(1, 3, 6'd3);
        prog[9] = mk(1, 3, 6'd4);
        valid_after = 1_000_000;
        reset_dut();
        run_until_halt("t3_halt", 100);
        chk_log("t3_rng0", 0, 32'h1);
        chk_log("t3_rng1", 1, 32'h0);
        chk_log("t3_rng_tap", 2, 32'h8000_0004);
        chk_log("t3_write_wins", 3, 32'h1234);

        // 4: REF/DEF indirection and REF truncation
        clear_prog();
        prog[0] = mk(0, 63, 6'd10);
        prog[1] = mk(0, 32'hDEAD, 6'd11);
        prog[2] = mk(0, 2, 6'd10);
        prog[3] = mk(1, 11, g(5));
        prog[4] = mk(0, 32'h1FF, 6'd10);
        prog[5] = mk(1, 11, g(6));
        prog[6] = mk(1, 32'(g(5)), 6'd4);
        prog[7] = mk(1, 32'(g(6)), 6'd4);
        prog[8] = mk(1, 10, 6'd4);
        reset_dut();
        run_until_halt("t4_halt", 100);
        chk_log("t4_g5", 0, 0);
        chk_log("t4_g6", 1, 32'hDEAD);
        chk_log("t4_ref", 2, 63);

        // 5: jumps and PC wrap on skip
        clear_prog();
        prog[0]     = mk(0, 32'h10, 6'd0);
        prog[8'h10] = mk(0, 32'hFF, 6'd0);
        prog[8'hFF] = mk(0, 0, 6'd8);
        prog[1]     = mk(1, 0, 6'd4);
        reset_dut();
        run_until_halt("t5_halt", 100);
        chk("t5_count", alu_log.size(), 1);
        chk_log("t5_pc_wrapped", 0, 1);

        // 6: HALT absorbs ALU pulses; async reset during WAIT
        clear_prog();
        prog[0] = mk(0, 3, 6'd1);
        prog[1] = mk(1, 1, 6'd4);
        prog[2] = mk(0, 0, 6'd13);
        reset_dut();
        run_until_halt("t6_halt", 100);
        chk_log("t6_status", 0, 3);
        alu_mode = 0;
        repeat (20) @(posedge clk);
        #1;
        chk("t6_halted", 32'(halted_o), 1);
        chk("t6_no_fetch", 32'(bus.o_imem_en), 0);
        chk("t6_pc_frozen", 32'(pc_o), 3);
        alu_mode = 1;
        clear_prog();
        prog[0] = mk(0, 5, 6'd0);
        prog[5] = mk(1, 4, g(0));
        reset_dut();
        repeat (5) @(posedge clk);
        #1;
        chk("t6_wait_pc", 32'(pc_o), 5);
        chk("t6_wait_no_fetch", 32'(bus.o_imem_en), 0);
        #1 rst_n = 0;
        #1;
        chk("t6_rst_pc", 32'(pc_o), 0);
        chk("t6_rst_fetch", 32'(bus.o_imem_en), 1);
        chk("t6_rst_halted", 32'(halted_o), 0);
        chk("t6_rst_no_dv", 32'(bus.o_alu_data_valid), 0);
        chk("t6_rst_no_empty", 32'(bus.o_alu_result_empty), 0);

        // random programs against the model
        alu_mode = 0;
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < 256; i++) begin
                logic [5:0] dd;
                logic [31:0] ss;
                bit xx;
                xx = 1'($urandom_range(0, 1));
                dd = 6'($urandom_range(0, 63));
                if (dd == 6'd13 && $urandom_range(0, 15) != 0) dd = 6'd12;
                ss = $urandom;
                if (!xx && $urandom_range(0, 3) == 0) ss = 0;
                prog[i] = mk(xx, ss, dd);
            end
            reset_dut();
            for (int k = 0; k < 500 && !halted_o; k++) @(posedge clk);
            repeat (5) @(posedge clk);
        end

        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
endmodule
